// File: rtl/rtype_pkg.sv
// Shared constants for the R-type sequencer: states, opcode/funct codes, field ranges.
package rtype_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] EXEC = 3'd2;
    localparam logic [2:0] WB   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [5:0] OPC_RTYPE  = 6'h00;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

endpackage

// File: rtl/rtype_exec_ctrl_funct_check.sv
// Combinational legality decode: R-type opcode with a supported funct.
module rtype_funct_check
    import rtype_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       legal_c
);

    // Only the listed R-type functions are executed; everything else is rejected.
    always_comb begin
        legal_c = 1'b0;
        if (opcode == OPC_RTYPE) begin
            case (funct)
                FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
                FUNCT_AND, FUNCT_OR, FUNCT_NOR, FUNCT_SLT,
                FUNCT_SLL, FUNCT_SRL: legal_c = 1'b1;
                default:              legal_c = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type sequencer: accept, read RF, run ALU, write back, report done.
module rtype_exec_ctrl
    import rtype_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter bit          SKIP_R0_WB  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [5:0]  alu_funct,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        done,
    output logic        illegal,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned KEEP_W  = 26;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [KEEP_W-1:0]  instr_q, instr_d;
    logic [31:0]        op1_q, op1_d, op2_q, op2_d;
    logic [31:0]        result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zero_q, zero_d, carry_q, carry_d;
    logic               rej_q, rej_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic               legal_c;

    // Opcode is only needed at the accept edge, so it is decoded from the port.
    rtype_funct_check u_funct_check (
        .opcode  (instr[OPC_MSB:OPC_LSB]),
        .funct   (instr[FUNCT_MSB:FUNCT_LSB]),
        .legal_c (legal_c)
    );

    // Next-state, datapath captures and registered strobes.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        rej_d     = rej_q;

        case (state_q)
            IDLE: begin
                if (instr_valid && ready_q) begin
                    instr_d = instr[KEEP_W-1:0];
                    rej_d   = ~legal_c;
                    state_d = legal_c ? READ : DONE;
                end
            end
            READ: begin
                op1_d   = rf_rdata1;
                op2_d   = rf_rdata2;
                cnt_d   = '0;
                state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    carry_d  = alu_carry;
                    state_d  = WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d   = (state_d == IDLE);
        we_d      = (state_d == WB) &&
                    !(SKIP_R0_WB && (instr_q[RD_MSB:RD_LSB] == 5'd0));
        done_d    = (state_d == DONE);
        illegal_d = (state_d == DONE) && rej_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            rej_q     <= 1'b0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            rej_q     <= rej_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = ready_q;
    assign rf_raddr1   = instr_q[RS_MSB:RS_LSB];
    assign rf_raddr2   = instr_q[RT_MSB:RT_LSB];
    assign alu_funct   = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign alu_shamt   = instr_q[SHAMT_MSB:SHAMT_LSB];
    assign rf_waddr    = instr_q[RD_MSB:RD_LSB];
    assign alu_src1    = op1_q;
    assign alu_src2    = op2_q;
    assign rf_wdata    = result_q;
    assign rf_we       = we_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign carry       = carry_q;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Directed bench for rtype_exec_ctrl with a register-file array and reference ALU.
module tb_rtype_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_valid3;
    logic [31:0] instr;
    logic [31:0] rf_mem [32];

    logic        instr_ready, rf_we, done, illegal, zero, carry, alu_zero, alu_carry;
    logic [4:0]  rf_raddr1, rf_raddr2, alu_shamt, rf_waddr;
    logic [5:0]  alu_funct;
    logic [31:0] rf_rdata1, rf_rdata2, alu_src1, alu_src2, alu_result, rf_wdata, result;

    logic        instr_ready3, rf_we3, done3, illegal3, zero3, carry3, alu_zero3, alu_carry3;
    logic [4:0]  rf_raddr1_3, rf_raddr2_3, alu_shamt3, rf_waddr3;
    logic [5:0]  alu_funct3;
    logic [31:0] rf_rdata1_3, rf_rdata2_3, alu_src1_3, alu_src2_3, alu_result3, rf_wdata3, result3;

    int n_cmp  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int we_cnt3 = 0;

    always #5 clk = ~clk;

    // Reference ALU: {carry, result}.
    function automatic logic [32:0] alu_f(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'h20, 6'h21: alu_f = {1'b0, a} + {1'b0, b};
            6'h22, 6'h23: alu_f = {1'b0, a} + {1'b0, ~b} + 33'd1;
            6'h24:        alu_f = {1'b0, a & b};
            6'h25:        alu_f = {1'b0, a | b};
            6'h27:        alu_f = {1'b0, ~(a | b)};
            6'h2A:        alu_f = {32'd0, ($signed(a) < $signed(b))};
            6'h00:        alu_f = {1'b0, b << sh};
            6'h02:        alu_f = {1'b0, b >> sh};
            default:      alu_f = 33'd0;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] f);
        rtype = {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    assign rf_rdata1   = rf_mem[rf_raddr1];
    assign rf_rdata2   = rf_mem[rf_raddr2];
    assign {alu_carry, alu_result} = alu_f(alu_funct, alu_shamt, alu_src1, alu_src2);
    assign alu_zero    = (alu_result == 32'd0);

    assign rf_rdata1_3 = rf_mem[rf_raddr1_3];
    assign rf_rdata2_3 = rf_mem[rf_raddr2_3];
    assign {alu_carry3, alu_result3} = alu_f(alu_funct3, alu_shamt3, alu_src1_3, alu_src2_3);
    assign alu_zero3   = (alu_result3 == 32'd0);

    rtype_exec_ctrl #(.EXEC_CYCLES(1), .SKIP_R0_WB(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_src1(alu_src1),
        .alu_src2(alu_src2), .alu_funct(alu_funct), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done(done),
        .illegal(illegal), .result(result), .zero(zero), .carry(carry)
    );

    rtype_exec_ctrl #(.EXEC_CYCLES(3), .SKIP_R0_WB(1'b1)) dut3 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
        .instr(instr), .rf_raddr1(rf_raddr1_3), .rf_raddr2(rf_raddr2_3),
        .rf_rdata1(rf_rdata1_3), .rf_rdata2(rf_rdata2_3), .alu_src1(alu_src1_3),
        .alu_src2(alu_src2_3), .alu_funct(alu_funct3), .alu_shamt(alu_shamt3),
        .alu_result(alu_result3), .alu_zero(alu_zero3), .alu_carry(alu_carry3),
        .rf_we(rf_we3), .rf_waddr(rf_waddr3), .rf_wdata(rf_wdata3), .done(done3),
        .illegal(illegal3), .result(result3), .zero(zero3), .carry(carry3)
    );

    // Count write strobes seen at each clock edge.
    always @(posedge clk) begin
        if (rf_we)  we_cnt  <= we_cnt + 1;
        if (rf_we3) we_cnt3 <= we_cnt3 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_mem[1] = 32'h5;        rf_mem[2] = 32'h3;
        rf_mem[4] = 32'h1234;     rf_mem[5] = 32'h1234;
        rf_mem[6] = 32'hFFFF_FFFF; rf_mem[7] = 32'h1;
        rst = 1'b1; instr_valid = 1'b0; instr_valid3 = 1'b0; instr = 32'd0;
        tick(); tick();

        // Reset state
        chk("rst_ready",   32'(instr_ready), 32'd1);
        chk("rst_we",      32'(rf_we), 32'd0);
        chk("rst_done",    32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_result",  result, 32'd0);
        chk("rst_flags",   32'({zero, carry}), 32'd0);
        chk("rst_src1",    alu_src1, 32'd0);
        rst = 1'b0;
        tick();

        // ADD r3 = r1 + r2, EXEC_CYCLES=1: done at t+4
        instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); instr_valid = 1'b1;
        chk("add_ready_t", 32'(instr_ready), 32'd1);
        tick(); instr_valid = 1'b0;
        chk("add_ready_t1", 32'(instr_ready), 32'd0);
        tick();
        chk("add_src1", alu_src1, 32'h5);
        chk("add_src2", alu_src2, 32'h3);
        tick();
        chk("add_we_t3",    32'(rf_we), 32'd1);
        chk("add_waddr",    32'(rf_waddr), 32'd3);
        chk("add_wdata",    rf_wdata, 32'h8);
        chk("add_done_t3",  32'(done), 32'd0);
        tick();
        chk("add_done_t4",  32'(done), 32'd1);
        chk("add_illegal",  32'(illegal), 32'd0);
        chk("add_result",   result, 32'h8);
        chk("add_zero",     32'(zero), 32'd0);
        chk("add_we_t4",    32'(rf_we), 32'd0);
        tick();
        chk("add_done_t5",  32'(done), 32'd0);
        chk("add_ready_t5", 32'(instr_ready), 32'd1);
        chk("add_we_cnt",   32'(we_cnt), 32'd1);

        // SUB r4 = r4 - r5 on the EXEC_CYCLES=3 instance: done at t+6
        instr = rtype(5'd4, 5'd5, 5'd4, 6'h22); instr_valid3 = 1'b1;
        tick(); instr_valid3 = 1'b0;
        tick(); tick(); tick();
        chk("sub_we_t4",   32'(rf_we3), 32'd0);
        tick();
        chk("sub_we_t5",   32'(rf_we3), 32'd1);
        chk("sub_waddr",   32'(rf_waddr3), 32'd4);
        chk("sub_wdata",   rf_wdata3, 32'd0);
        chk("sub_done_t5", 32'(done3), 32'd0);
        tick();
        chk("sub_done_t6", 32'(done3), 32'd1);
        chk("sub_result",  result3, 32'd0);
        chk("sub_zero",    32'(zero3), 32'd1);
        chk("sub_carry",   32'(carry3), 32'd1);
        tick();
        chk("sub_we_cnt",  32'(we_cnt3), 32'd1);
        chk("sub_ready",   32'(instr_ready3), 32'd1);

        // LW opcode: rejected, done at t+1, flags untouched
        instr = 32'h8C22_0000; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        chk("lw_done",    32'(done), 32'd1);
        chk("lw_illegal", 32'(illegal), 32'd1);
        chk("lw_result",  result, 32'h8);
        tick();
        chk("lw_done_off", 32'(done), 32'd0);
        chk("lw_ill_off",  32'(illegal), 32'd0);
        chk("lw_ready",    32'(instr_ready), 32'd1);

        // MULT funct: rejected
        instr = rtype(5'd1, 5'd2, 5'd3, 6'h18); instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        chk("mult_done",    32'(done), 32'd1);
        chk("mult_illegal", 32'(illegal), 32'd1);
        chk("mult_flags",   32'({zero, carry}), 32'd0);
        tick();
        chk("rej_we_cnt",   32'(we_cnt), 32'd1);

        // ADD with rd=0: write suppressed, result still captured
        instr = rtype(5'd1, 5'd7, 5'd0, 6'h20); instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick(); tick();
        chk("r0_we_t3", 32'(rf_we), 32'd0);
        tick();
        chk("r0_done",   32'(done), 32'd1);
        chk("r0_result", result, 32'h6);
        tick();
        chk("r0_we_cnt", 32'(we_cnt), 32'd1);

        // valid held high; instr and RF change mid-flight
        instr = rtype(5'd6, 5'd1, 5'd8, 6'h25); instr_valid = 1'b1;
        tick();
        instr = rtype(5'd1, 5'd7, 5'd9, 6'h24);
        chk("hold_ready_t1", 32'(instr_ready), 32'd0);
        tick();
        rf_mem[6] = 32'd0;
        tick();
        chk("hold_we_a",    32'(rf_we), 32'd1);
        chk("hold_waddr_a", 32'(rf_waddr), 32'd8);
        chk("hold_wdata_a", rf_wdata, 32'hFFFF_FFFF);
        tick();
        chk("hold_done_a",   32'(done), 32'd1);
        chk("hold_result_a", result, 32'hFFFF_FFFF);
        chk("hold_ready_t4", 32'(instr_ready), 32'd0);
        tick();
        chk("hold_ready_t5", 32'(instr_ready), 32'd1);
        chk("hold_done_t5",  32'(done), 32'd0);
        tick(); instr_valid = 1'b0;
        chk("hold_ready_t6", 32'(instr_ready), 32'd0);
        tick(); tick();
        chk("hold_we_b",    32'(rf_we), 32'd1);
        chk("hold_waddr_b", 32'(rf_waddr), 32'd9);
        tick();
        chk("hold_done_b",   32'(done), 32'd1);
        chk("hold_result_b", result, 32'h1);
        tick();
        chk("hold_we_cnt",   32'(we_cnt), 32'd3);

        // Reset during WB
        instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick(); tick();
        chk("mid_we_wb", 32'(rf_we), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_we",     32'(rf_we), 32'd0);
        chk("mid_done",   32'(done), 32'd0);
        chk("mid_ready",  32'(instr_ready), 32'd1);
        chk("mid_result", result, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_idle_done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
